apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge_pkg.sv | 7 +
 rtl/apb_addr_decoder.sv | 31 +++
 rtl/apb_master_bridge.sv | 95 +++++++++
 tb/tb_apb_master_bridge.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_bridge_pkg.sv
// apb_master_bridge_pkg: shared FSM states and address-map constants for the APB bridge
package apb_master_bridge_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam logic [19:0] BASE_PAGE = 20'h10000;
  localparam int PAGE_W = 12;
  localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: page decode of an APB address into a one-hot slave select plus PRDATA/PREADY mux
module apb_addr_decoder
  import apb_master_bridge_pkg::*;
#(
  parameter int NSLV = 4
) (
  input  logic [31:0]           i_addr,
  input  logic [NSLV-1:0][31:0] i_prdata,
  input  logic [NSLV-1:0]       i_pready,
  output logic [NSLV-1:0]       o_sel,
  output logic                  o_hit,
  output logic [31:0]           o_prdata,
  output logic                  o_pready
);
  logic w_unused_off;
  assign w_unused_off = ^i_addr[PAGE_W-1:0];
  // each slave owns one 4 KiB page starting at BASE_PAGE; only the selected slave's bus is forwarded
  always_comb begin
    o_sel = '0;
    o_prdata = '0;
    o_pready = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (i_addr[31:PAGE_W] == BASE_PAGE + 20'(i)) begin
        o_sel[i] = 1'b1;
        o_prdata = i_prdata[i];
        o_pready = i_pready[i];
      end
    end
    o_hit = |o_sel;
  end
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: CPU request strobe to APB master with slave decode, wait states and access timeout
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int NSLV = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  transfer,
  input  logic                  write,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  ready,
  output logic                  slverr,
  output logic [31:0]           PADDR,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  output logic                  PENABLE,
  output logic [NSLV-1:0]       PSEL,
  input  logic [NSLV-1:0][31:0] PRDATA,
  input  logic [NSLV-1:0]       PREADY
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_paddr;
  logic [31:0]     r_pwdata;
  logic            r_pwrite;
  logic            r_penable;
  logic            r_sel_en;
  logic [31:0]     r_rdata;
  logic            r_ready;
  logic            r_slverr;
  logic [NSLV-1:0] w_sel;
  logic            w_hit;
  logic [31:0]     w_prdata;
  logic            w_pready;
  logic            w_done;
  logic            w_err;
  logic            w_start;

  apb_addr_decoder #(.NSLV(NSLV)) u_dec (
    .i_addr  (r_paddr),
    .i_prdata(PRDATA),
    .i_pready(PREADY),
    .o_sel   (w_sel),
    .o_hit   (w_hit),
    .o_prdata(w_prdata),
    .o_pready(w_pready)
  );

  assign w_done  = (r_state == ACCESS) && (!w_hit || w_pready || r_cnt == CW'(TIMEOUT - 1));
  assign w_err   = !w_hit || !w_pready;
  assign w_start = transfer && (r_state == IDLE || w_done);

  assign PADDR   = r_paddr;
  assign PWRITE  = r_pwrite;
  assign PWDATA  = r_pwdata;
  assign PENABLE = r_penable;
  assign PSEL    = r_sel_en ? w_sel : '0;
  assign rdata   = r_rdata;
  assign ready   = r_ready;
  assign slverr  = r_slverr;

  // IDLE/SETUP/ACCESS sequencer; a completing ACCESS may chain straight into the next SETUP
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_penable <= 1'b0;
      r_sel_en  <= 1'b0;
      r_rdata   <= '0;
      r_ready   <= 1'b0;
      r_slverr  <= 1'b0;
    end else begin
      if (w_start) begin
        r_paddr  <= addr;
        r_pwrite <= write;
        r_pwdata <= wdata;
      end
      r_state   <= w_start ? SETUP : (r_state == SETUP) ? ACCESS : w_done ? IDLE : r_state;
      r_cnt     <= (r_state == ACCESS) ? r_cnt + 1'b1 : '0;
      r_penable <= (r_state == SETUP) || (r_state == ACCESS && !w_done);
      r_sel_en  <= w_start || (r_state == SETUP) || (r_state == ACCESS && !w_done);
      r_ready   <= w_done;
      r_slverr  <= w_done && w_err;
      r_rdata   <= (w_done && !w_err && !r_pwrite) ? w_prdata : '0;
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: randomized APB bridge bench checked against a cycle-timeline transaction model
module tb_apb_master_bridge;
  localparam int NSLV = 4;
  localparam int TO = 8;

  logic                  PCLK = 1'b0;
  logic                  PRESET = 1'b1;
  logic                  transfer = 1'b0;
  logic                  write = 1'b0;
  logic [31:0]           addr = '0;
  logic [31:0]           wdata = '0;
  logic [31:0]           rdata;
  logic                  ready;
  logic                  slverr;
  logic [31:0]           PADDR;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic                  PENABLE;
  logic [NSLV-1:0]       PSEL;
  logic [NSLV-1:0][31:0] PRDATA = '0;
  logic [NSLV-1:0]       PREADY = '0;

  int checks = 0;
  int failures = 0;

  bit          q_wr[$];
  logic [31:0] q_a[$];
  logic [31:0] q_d[$];
  logic [31:0] q_pr[$];
  int          q_lat[$];

  apb_master_bridge #(.TIMEOUT(TO), .NSLV(NSLV)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .slverr(slverr),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE),
    .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  function automatic int slv_of(input logic [31:0] a);
    int p;
    p = int'(a[31:12]) - 32'h10000;
    return (p >= 0 && p < NSLV) ? p : -1;
  endfunction

  task automatic push(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] pr, input int lat);
    q_wr.push_back(wr);
    q_a.push_back(a);
    q_d.push_back(d);
    q_pr.push_back(pr);
    q_lat.push_back(lat);
  endtask

  task automatic noise();
    for (int k = 0; k < NSLV; k++) begin
      PRDATA[k] = $urandom;
      PREADY[k] = 1'($urandom);
    end
  endtask

  // Runs every queued request back to back: request i+1 is offered in request i's completing ACCESS cycle.
  task automatic run_seq(input string tag);
    int m, last, act, rdy, cur;
    int st[16], n[16], s[16];
    logic [NSLV-1:0] esel;
    bit een, eerr;
    logic [31:0] erd;
    m = q_a.size();
    for (int i = 0; i < m; i++) begin
      s[i] = slv_of(q_a[i]);
      n[i] = (s[i] < 0) ? 1 : (q_lat[i] + 1 < TO ? q_lat[i] + 1 : TO);
      st[i] = (i == 0) ? 1 : st[i-1] + n[i-1] + 1;
    end
    last = st[m-1] + n[m-1] + 1;
    @(negedge PCLK);
    noise();
    transfer = 1'b1;
    write = q_wr[0];
    addr = q_a[0];
    wdata = q_d[0];
    for (int t = 1; t <= last; t++) begin
      @(negedge PCLK);
      act = -1;
      rdy = -1;
      cur = 0;
      for (int i = 0; i < m; i++) begin
        if (t >= st[i] && t <= st[i] + n[i]) act = i;
        if (t == st[i] + n[i] + 1) rdy = i;
        if (t >= st[i]) cur = i;
      end
      esel = '0;
      if (act >= 0 && s[act] >= 0) esel[s[act]] = 1'b1;
      een = (act >= 0) && (t > st[act]);
      checks++;
      if ({PSEL, PENABLE, ready} !== {esel, een, rdy >= 0}) begin
        failures++;
        $display("FAIL %s ctl t=%0d psel/penable/ready got=%b/%b/%b want=%b/%b/%b",
                 tag, t, PSEL, PENABLE, ready, esel, een, rdy >= 0);
      end
      checks++;
      if ({PADDR, PWRITE, PWDATA} !== {q_a[cur], q_wr[cur], q_d[cur]}) begin
        failures++;
        $display("FAIL %s latch t=%0d got=%h/%b/%h want=%h/%b/%h",
                 tag, t, PADDR, PWRITE, PWDATA, q_a[cur], q_wr[cur], q_d[cur]);
      end
      if (rdy >= 0) begin
        eerr = (s[rdy] < 0) || (q_lat[rdy] >= TO);
        erd = (!eerr && !q_wr[rdy]) ? q_pr[rdy] : 32'h0;
        checks++;
        if ({slverr, rdata} !== {eerr, erd}) begin
          failures++;
          $display("FAIL %s resp t=%0d slverr/rdata got=%b/%h want=%b/%h",
                   tag, t, slverr, rdata, eerr, erd);
        end
      end
      noise();
      if (act >= 0 && s[act] >= 0) begin
        PREADY[s[act]] = (t - st[act] == q_lat[act] + 1);
        if (t - st[act] == q_lat[act] + 1) PRDATA[s[act]] = q_pr[act];
      end
      if (act >= 0 && t == st[act] + n[act] && act + 1 < m) begin
        transfer = 1'b1;
        write = q_wr[act+1];
        addr = q_a[act+1];
        wdata = q_d[act+1];
      end else begin
        transfer = (act >= 0 && t < st[act] + n[act]) ? 1'($urandom) : 1'b0;
        write = 1'($urandom);
        addr = $urandom;
        wdata = $urandom;
      end
    end
    transfer = 1'b0;
    PREADY = '0;
    q_wr.delete();
    q_a.delete();
    q_d.delete();
    q_pr.delete();
    q_lat.delete();
  endtask

  task automatic test_reset();
    #3 PRESET = 1'b0;
    #1;
    checks++;
    if ({PSEL, PENABLE, ready, slverr, rdata, PADDR, PWDATA, PWRITE} !== '0) begin
      failures++;
      $display("FAIL reset_async outputs got psel=%b pen=%b rdy=%b err=%b rdata=%h paddr=%h pwdata=%h pwrite=%b want all zero",
               PSEL, PENABLE, ready, slverr, rdata, PADDR, PWDATA, PWRITE);
    end
    transfer = 1'b1;
    addr = 32'h1000_0000;
    repeat (2) @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, ready, PADDR} !== '0) begin
      failures++;
      $display("FAIL reset_hold got psel=%b pen=%b rdy=%b paddr=%h want zero", PSEL, PENABLE, ready, PADDR);
    end
    transfer = 1'b0;
    PRESET = 1'b1;
  endtask

  task automatic test_write();
    push(1'b1, 32'h1000_1004, 32'h0000_00A5, $urandom, 0);
    run_seq("write");
  endtask

  task automatic test_read_wait();
    push(1'b0, 32'h1000_2008, $urandom, 32'h0000_0019, 3);
    run_seq("read_wait");
  endtask

  task automatic test_unmapped();
    push(1'b0, 32'h2000_0000, $urandom, $urandom, 0);
    run_seq("unmapped");
    push(1'b1, 32'h1000_4000, $urandom, $urandom, 0);
    run_seq("unmapped_page4");
  endtask

  task automatic test_timeout();
    push(1'b0, 32'h1000_3000, $urandom, $urandom, 1000);
    run_seq("timeout");
    push(1'b0, 32'h1000_3010, $urandom, $urandom, TO - 1);
    run_seq("timeout_edge_ok");
  endtask

  task automatic test_back_to_back();
    push(1'b1, 32'h1000_0000, $urandom, $urandom, $urandom_range(0, 2));
    push(1'b0, 32'h1000_1004, $urandom, $urandom, $urandom_range(0, 2));
    run_seq("back_to_back");
  endtask

  task automatic test_random();
    int len, r;
    logic [19:0] pg;
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(1, 3);
      for (int j = 0; j < len; j++) begin
        r = $urandom_range(0, 6);
        pg = (r < 6) ? 20'h10000 + 20'(r) : 20'h2ABCD;
        push(1'($urandom), {pg, 12'($urandom)}, $urandom, $urandom, $urandom_range(0, 9));
      end
      run_seq("random");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge PCLK);
    transfer = 1'b1;
    write = 1'b0;
    addr = 32'h1000_1000;
    PREADY = '0;
    @(negedge PCLK);
    transfer = 1'b0;
    repeat (2) @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE} !== {4'b0010, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid pre psel/pen got=%b/%b want=0010/1", PSEL, PENABLE);
    end
    #2 PRESET = 1'b0;
    #1;
    checks++;
    if ({PSEL, PENABLE, ready} !== '0) begin
      failures++;
      $display("FAIL reset_mid drop psel/pen/rdy got=%b/%b/%b want zero", PSEL, PENABLE, ready);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge PCLK);
      checks++;
      if (ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid no_ready got=%b want=0", ready);
      end
    end
    PRESET = 1'b1;
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, ready} !== '0) begin
      failures++;
      $display("FAIL reset_mid idle psel/pen/rdy got=%b/%b/%b want zero", PSEL, PENABLE, ready);
    end
    push(1'b1, 32'h1000_2000 | 32'($urandom_range(0, 4095)), $urandom, $urandom, $urandom_range(0, 2));
    run_seq("after_reset");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_unmapped();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge PCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
